// File: rtl/johnson_dec_pkg.sv
// Shared types and sizing helpers for the Johnson-code decoder.
package johnson_dec_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam int unsigned GOOD_CNT_W = 4;
    localparam int unsigned ERR_CNT_W  = 8;

    // Bits needed to hold a position 0..2N-1 of an N-bit Johnson counter.
    function automatic int unsigned index_width(input int unsigned width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code decoder: flags legal codes and gives their position.
module johnson_code_decode
    import johnson_dec_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = index_width(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [IDX_W-1:0] index
);

    logic [WIDTH-1:0] inv;
    logic [IDX_W-1:0] ones;

    // Rising half is LSB-justified ones; falling half is MSB-justified ones.
    always_comb begin
        inv  = ~code;
        ones = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones = ones + IDX_W'(code[i]);
        end
        legal = 1'b0;
        index = '0;
        if (!code[WIDTH-1]) begin
            legal = ((code & (code + WIDTH'(1))) == '0);
            index = ones;
        end else begin
            legal = ((inv & (inv + WIDTH'(1))) == '0);
            index = IDX_W'(WIDTH) + (IDX_W'(WIDTH) - ones);
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter monitor: decodes samples, classifies steps and tracks lock.
// Optional saturating error counter built when JOHNSON_DEC_ERRCNT_EN is defined.
module johnson_decoder
    import johnson_dec_pkg::*;
#(
    parameter  int unsigned WIDTH      = 4,
    parameter  int unsigned LOCK_COUNT = 3,
    localparam int unsigned IDX_W      = index_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     q_in,
    output logic [IDX_W-1:0]     index,
    output logic                 idx_valid,
    output logic                 illegal,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned LAST_IDX = 2 * WIDTH - 1;

    state_t                state;
    state_t                state_next;
    logic                  dec_legal;
    logic [IDX_W-1:0]      dec_index;
    logic [IDX_W-1:0]      prev;
    logic [IDX_W-1:0]      prev_next;
    logic [IDX_W-1:0]      prev_inc;
    logic [IDX_W-1:0]      index_next;
    logic [GOOD_CNT_W-1:0] good_cnt;
    logic [GOOD_CNT_W-1:0] good_cnt_next;
    logic                  valid_next;
    logic                  illegal_next;
    logic                  step_err_next;
    logic                  is_hold;
    logic                  is_good;

    johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
        .code  (q_in),
        .legal (dec_legal),
        .index (dec_index)
    );

    assign prev_inc = (prev == IDX_W'(LAST_IDX)) ? '0 : prev + IDX_W'(1);
    assign is_hold  = (dec_index == prev);
    assign is_good  = (dec_index == prev_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Lock acquisition: illegal codes always drop back to UNLOCKED.
    always_comb begin
        state_next = state;
        if (sample_en) begin
            if (!dec_legal) begin
                state_next = UNLOCKED;
            end else begin
                case (state)
                    UNLOCKED: state_next = ACQUIRE;
                    ACQUIRE: begin
                        if (is_good && (good_cnt + GOOD_CNT_W'(1) == GOOD_CNT_W'(LOCK_COUNT))) begin
                            state_next = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (!is_hold && !is_good) begin
                            state_next = ACQUIRE;
                        end
                    end
                    default: state_next = UNLOCKED;
                endcase
            end
        end
    end

    // Next values of the registered datapath and pulse outputs.
    always_comb begin
        index_next    = index;
        prev_next     = prev;
        good_cnt_next = good_cnt;
        valid_next    = 1'b0;
        illegal_next  = 1'b0;
        step_err_next = 1'b0;
        if (sample_en) begin
            if (!dec_legal) begin
                illegal_next  = 1'b1;
                good_cnt_next = '0;
            end else begin
                valid_next = 1'b1;
                index_next = dec_index;
                prev_next  = dec_index;
                case (state)
                    ACQUIRE, LOCKED: begin
                        if (is_good) begin
                            if (state == ACQUIRE) begin
                                good_cnt_next = good_cnt + GOOD_CNT_W'(1);
                            end
                        end else if (!is_hold) begin
                            step_err_next = 1'b1;
                            good_cnt_next = '0;
                        end
                    end
                    default: good_cnt_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index     <= '0;
            prev      <= '0;
            good_cnt  <= '0;
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            step_err  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            index     <= index_next;
            prev      <= prev_next;
            good_cnt  <= good_cnt_next;
            idx_valid <= valid_next;
            illegal   <= illegal_next;
            step_err  <= step_err_next;
            locked    <= (state_next == LOCKED);
        end
    end

`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_q;

    // Counts each error pulse as it is issued; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if ((illegal_next || step_err_next) && (err_q != '1)) begin
            err_q <= err_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (WIDTH=4, LOCK_COUNT=3) against a table-driven model.
module tb_johnson_decoder;

    localparam int N    = 4;
    localparam int NPOS = 2 * N;
    localparam int LOCK = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [3:0] q_in;
    logic [2:0] index;
    logic       idx_valid;
    logic       illegal;
    logic       step_err;
    logic       locked;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (0=unlocked, 1=acquire, 2=locked).
    int   m_state = 0;
    int   m_prev  = 0;
    int   m_good  = 0;
    int   m_index = 0;
    logic m_valid = 0, m_illegal = 0, m_step = 0, m_locked = 0;
    int   m_err   = 0;

    johnson_decoder #(.WIDTH(N), .LOCK_COUNT(LOCK)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .q_in      (q_in),
        .index     (index),
        .idx_valid (idx_valid),
        .illegal   (illegal),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Position k: k ones from the LSB for k<=N, else ones in the top 2N-k bits.
    function automatic logic [3:0] code_of(input int k);
        logic [3:0] c;
        c = '0;
        for (int b = 0; b < N; b++) begin
            if (k <= N) c[b] = (b < k);
            else        c[b] = (b >= k - N);
        end
        return c;
    endfunction

    task automatic model_err_inc();
`ifdef JOHNSON_DEC_ERRCNT_EN
        if (m_err < 255) m_err++;
`endif
    endtask

    task automatic model_step(input logic rst, input logic en, input logic [3:0] q);
        int k;
        k = -1;
        for (int i = 0; i < NPOS; i++) if (code_of(i) == q) k = i;
        m_valid = 0; m_illegal = 0; m_step = 0;
        if (rst) begin
            m_state = 0; m_prev = 0; m_good = 0; m_index = 0; m_err = 0;
        end else if (en) begin
            if (k < 0) begin
                m_illegal = 1; m_state = 0; m_good = 0;
                model_err_inc();
            end else begin
                m_valid = 1;
                m_index = k;
                if (m_state == 0) begin
                    m_state = 1; m_good = 0;
                end else if (k == (m_prev + 1) % NPOS) begin
                    if (m_state == 1) begin
                        m_good++;
                        if (m_good == LOCK) m_state = 2;
                    end
                end else if (k != m_prev) begin
                    m_step = 1; m_state = 1; m_good = 0;
                    model_err_inc();
                end
                m_prev = k;
            end
        end
        m_locked = (m_state == 2);
    endtask

    task automatic cyc(input logic rst, input logic en, input logic [3:0] q);
        reset = rst; sample_en = en; q_in = q;
        @(posedge clk);
        #1;
        model_step(rst, en, q);
    endtask

    task automatic test_reset();
        cyc(1, 1, 4'b0101);
        cyc(1, 0, 4'b0000);
        n_checks++;
        if ({index, idx_valid, illegal, step_err, locked, err_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: got idx=%0d v=%b ill=%b se=%b lk=%b err=%0d, need all 0",
                     index, idx_valid, illegal, step_err, locked, err_count);
        end
    endtask

    task automatic test_lock_acquire();
        cyc(1, 0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, code_of(i));
            n_checks++;
            if (idx_valid !== 1'b1 || index !== 3'(i) || step_err !== 1'b0 || locked !== (i == 3)) begin
                n_fail++;
                $display("FAIL lock_acquire[%0d]: got v=%b idx=%0d se=%b lk=%b, need v=1 idx=%0d se=0 lk=%b",
                         i, idx_valid, index, step_err, locked, i, (i == 3));
            end
        end
    endtask

    task automatic test_sample_hold();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 4'($urandom_range(0, 15)));
            n_checks++;
            if (idx_valid !== 1'b0 || illegal !== 1'b0 || step_err !== 1'b0 || index !== 3'd3 || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL sample_hold: got v=%b ill=%b se=%b idx=%0d lk=%b, need 0 0 0 3 1",
                         idx_valid, illegal, step_err, index, locked);
            end
        end
    endtask

    task automatic test_wrap();
        for (int k = 4; k <= 8; k++) begin
            cyc(0, 1, code_of(k % NPOS));
            n_checks++;
            if (index !== 3'(k % NPOS) || step_err !== 1'b0 || locked !== 1'b1 || idx_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got idx=%0d se=%b lk=%b v=%b, need idx=%0d se=0 lk=1 v=1",
                         k, index, step_err, locked, idx_valid, k % NPOS);
            end
        end
    endtask

    task automatic test_step_err();
        cyc(1, 0, 4'b0000);
        cyc(0, 1, code_of(7));
        cyc(0, 1, code_of(0));
        cyc(0, 1, code_of(1));
        cyc(0, 1, code_of(2));
        n_checks++;
        if (locked !== 1'b1 || index !== 3'd2) begin
            n_fail++;
            $display("FAIL step_err_setup: got lk=%b idx=%0d, need lk=1 idx=2", locked, index);
        end
        cyc(0, 1, 4'b1110);
        n_checks++;
        if (step_err !== 1'b1 || index !== 3'd5 || locked !== 1'b0 || err_count !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL step_err: got se=%b idx=%0d lk=%b err=%0d, need se=1 idx=5 lk=0 err=%0d",
                     step_err, index, locked, err_count, m_err);
        end
    endtask

    task automatic test_illegal();
        cyc(0, 1, 4'b0101);
        n_checks++;
        if (illegal !== 1'b1 || idx_valid !== 1'b0 || step_err !== 1'b0 || index !== 3'd5 ||
            locked !== 1'b0 || err_count !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL illegal: got ill=%b v=%b se=%b idx=%0d lk=%b err=%0d, need 1 0 0 5 0 %0d",
                     illegal, idx_valid, step_err, index, locked, err_count, m_err);
        end
        // From UNLOCKED a jump must not be judged as a bad step.
        cyc(0, 1, code_of(0));
        n_checks++;
        if (step_err !== 1'b0 || idx_valid !== 1'b1 || index !== 3'd0) begin
            n_fail++;
            $display("FAIL illegal_unlocked: got se=%b v=%b idx=%0d, need se=0 v=1 idx=0",
                     step_err, idx_valid, index);
        end
    endtask

    task automatic test_err_saturate();
        int exp_err;
        cyc(1, 0, 4'b0000);
        for (int i = 1; i <= 257; i++) begin
            cyc(0, 1, (i % 2 == 0) ? 4'b1010 : 4'b0101);
`ifdef JOHNSON_DEC_ERRCNT_EN
            exp_err = (i > 255) ? 255 : i;
`else
            exp_err = 0;
`endif
            n_checks++;
            if (err_count !== 8'(exp_err) || illegal !== 1'b1) begin
                n_fail++;
                $display("FAIL err_saturate[%0d]: got err=%0d ill=%b, need err=%0d ill=1",
                         i, err_count, illegal, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        cyc(1, 0, 4'b0000);
        for (int i = 0; i < 4; i++) cyc(0, 1, code_of(i));
        cyc(0, 1, 4'b0110);
        cyc(0, 1, code_of(0));
        for (int i = 1; i < 4; i++) cyc(0, 1, code_of(i));
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_lock_setup: got lk=%b, need 1", locked);
        end
        cyc(1, 1, code_of(4));
        n_checks++;
        if ({index, idx_valid, illegal, step_err, locked, err_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid_lock: got idx=%0d v=%b ill=%b se=%b lk=%b err=%0d, need all 0",
                     index, idx_valid, illegal, step_err, locked, err_count);
        end
        cyc(0, 1, code_of(6));
        n_checks++;
        if (step_err !== 1'b0 || locked !== 1'b0 || index !== 3'd6) begin
            n_fail++;
            $display("FAIL reset_unlocked: got se=%b lk=%b idx=%0d, need se=0 lk=0 idx=6",
                     step_err, locked, index);
        end
    endtask

    task automatic test_random();
        logic       en, rst;
        logic [3:0] q;
        int         r;
        for (int n = 0; n < 400; n++) begin
            r   = int'($urandom_range(0, 9));
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            if (r <= 5)      q = code_of((m_prev + 1) % NPOS);
            else if (r == 6) q = code_of(m_prev);
            else if (r == 7) q = code_of(int'($urandom_range(0, NPOS - 1)));
            else             q = 4'($urandom_range(0, 15));
            cyc(rst, en, q);
            n_checks++;
            if (index !== 3'(m_index) || idx_valid !== m_valid || illegal !== m_illegal ||
                step_err !== m_step || locked !== m_locked || err_count !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL random[%0d] q=%b en=%b: got idx=%0d v=%b ill=%b se=%b lk=%b err=%0d, need %0d %b %b %b %b %0d",
                         n, q, en, index, idx_valid, illegal, step_err, locked, err_count,
                         m_index, m_valid, m_illegal, m_step, m_locked, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; q_in = 4'b0000;
        test_reset();
        test_lock_acquire();
        test_sample_hold();
        test_wrap();
        test_step_err();
        test_illegal();
        test_err_saturate();
        test_reset_mid_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the Johnson code width N (N >= 2), giving 2N legal codes.
REQ-002 The block SHALL have parameter LOCK_COUNT, default 3, meaning the consecutive good steps required to declare lock (1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic rises on its positive edge.
REQ-004 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port sample_en, input, 1, qualifying q_in for capture on this edge.
REQ-006 The block SHALL have port q_in, input, WIDTH, the Johnson-coded counter value under observation.
REQ-007 The block SHALL have port index, output, clog2(2*WIDTH), the decoded position 0..2N-1, registered.
REQ-008 The block SHALL have port idx_valid, output, 1, a one-cycle pulse marking a legal code decoded into index.
REQ-009 The block SHALL have port illegal, output, 1, a one-cycle pulse marking a sampled code outside the 2N legal set.
REQ-010 The block SHALL have port step_err, output, 1, a one-cycle pulse marking a legal code that is neither hold nor +1 from the previous index.
REQ-011 The block SHALL have port locked, output, 1, a level high while the FSM is in LOCKED.
REQ-012 The block SHALL have port err_count, output, 8, a saturating error counter (see REQ-027).

Function
REQ-013 The legal sequence SHALL be shift-left with inverted MSB feedback: for N=4, 0000,0001,0011,0111,1111,1110,1100,1000 = index 0..7.
REQ-014 Decode SHALL be: MSB=0 with contiguous LSB-justified ones -> index = popcount; MSB=1 with contiguous MSB-justified ones -> index = N + zero count; anything else is illegal.
REQ-015 Latency SHALL be one cycle: outputs on the edge after the sample_en edge reflect that sample; pulses last exactly one cycle.
REQ-016 With sample_en low, the block SHALL hold index, prev, FSM and counters, and drive all pulses low.
REQ-017 Step classification SHALL be against the stored previous legal index prev: equal = hold (no pulse, no count change); (prev+1) mod 2N = good; otherwise step_err. Wrap 2N-1 -> 0 is good.
REQ-018 An illegal code SHALL assert illegal only; it never asserts step_err or idx_valid, and index SHALL keep its old value.
REQ-019 The FSM SHALL have states UNLOCKED, ACQUIRE, LOCKED.
REQ-020 In UNLOCKED, a legal code SHALL store prev and go to ACQUIRE with good_cnt=0; no step check is made; an illegal code stays in UNLOCKED.
REQ-021 In ACQUIRE, a good step SHALL increment good_cnt and enter LOCKED on the step that makes good_cnt = LOCK_COUNT; step_err SHALL clear good_cnt and stay in ACQUIRE; an illegal code SHALL go to UNLOCKED.
REQ-022 In LOCKED, good or hold SHALL stay; step_err SHALL go to ACQUIRE with good_cnt=0; an illegal code SHALL go to UNLOCKED.
REQ-023 prev SHALL update on every legal sample, in any state.

Reset
REQ-024 On reset, the block SHALL clear index=0, idx_valid=0, illegal=0, step_err=0, locked=0, err_count=0, prev=0, good_cnt=0, and set state=UNLOCKED.
REQ-025 Reset SHALL override sample_en on the same edge; reset mid-lock SHALL drop locked on the next edge.

Configuration
REQ-026 Macro JOHNSON_DEC_ERRCNT_EN SHALL select whether the error counter is built.
REQ-027 With JOHNSON_DEC_ERRCNT_EN defined, err_count SHALL increment by 1 on each illegal or step_err pulse and saturate at 255.
REQ-028 Without JOHNSON_DEC_ERRCNT_EN, err_count SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-029 Package johnson_dec_pkg SHALL hold the FSM state enum and the index-width helper constant.
REQ-030 Sub-module johnson_code_decode SHALL be a purely combinational WIDTH-parameterised block giving legal and index.

Verification
REQ-031 Reset, then feed 0000,0001,0011,0111 with sample_en=1 -> idx_valid each cycle, index 0,1,2,3, locked high one cycle after 0111.
REQ-032 Locked, then feed 1000 followed by 0000 -> index 7 then 0, no step_err, locked stays high.
REQ-033 Locked at index 2 (0011), then feed 1110 -> step_err pulse, index=5, locked low, err_count +1.
REQ-034 Feed 0101 -> illegal pulse, idx_valid low, index unchanged, state UNLOCKED.
REQ-035 Force 256 illegal samples -> err_count=255 and holds there; without the macro, err_count=0 throughout.
REQ-036 Locked, then assert reset together with sample_en for one cycle -> next cycle all outputs 0 and state UNLOCKED.
